// File: rtl/prod_accum.sv
// Windowed accumulator for the registered multiplier product stream.
// It sums a programmable number of unsigned products, saturating at the accumulator width, and presents each window sum on a valid/ready output.
module prod_accum #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out,
  output logic                   overflow
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t state, state_next;

  logic [ACC_WIDTH-1:0]   acc, acc_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  logic [COUNT_WIDTH-1:0] len_q, len_next;
  logic                   sticky, sticky_next;

  logic                   accept;
  logic                   consume;
  logic                   load;
  logic [ACC_WIDTH:0]     in_ext;
  logic [ACC_WIDTH:0]     sum;
  logic                   sat;
  logic [ACC_WIDTH-1:0]   acc_sat;
  logic                   ovf_acc;
  logic [COUNT_WIDTH-1:0] eff_len;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   last_sample;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // acc and sticky are always zero in IDLE, so this one adder also serves the first sample of a window.
  assign in_ext  = (ACC_WIDTH + 1)'(in);
  assign sum     = {1'b0, acc} + in_ext;
  assign sat     = sum[ACC_WIDTH];
  assign acc_sat = sat ? '1 : sum[ACC_WIDTH-1:0];
  assign ovf_acc = sticky | sat;

  assign eff_len     = (length == '0) ? COUNT_WIDTH'(1) : length;
  assign count_inc   = count + COUNT_WIDTH'(1);
  assign last_sample = (state == IDLE) ? (eff_len == COUNT_WIDTH'(1))
                                       : (count_inc == len_q);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (accept) begin
      state_next = last_sample ? IDLE : ACCUM;
    end
  end

  // Datapath and output-load control
  always_comb begin
    acc_next    = acc;
    count_next  = count;
    len_next    = len_q;
    sticky_next = sticky;
    load        = 1'b0;
    if (clear) begin
      acc_next    = '0;
      count_next  = '0;
      sticky_next = 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        len_next = eff_len;
      end
      if (last_sample) begin
        load        = 1'b1;
        acc_next    = '0;
        count_next  = '0;
        sticky_next = 1'b0;
      end else begin
        acc_next    = acc_sat;
        count_next  = count_inc;
        sticky_next = ovf_acc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      count  <= '0;
      len_q  <= '0;
      sticky <= 1'b0;
    end else begin
      acc    <= acc_next;
      count  <= count_next;
      len_q  <= len_next;
      sticky <= sticky_next;
    end
  end

  // A load in the same cycle as a consume replaces the old result and keeps out_valid high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      out       <= acc_sat;
      out_valid <= 1'b1;
      overflow  <= ovf_acc;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum with ACC_WIDTH=9 so saturation is reachable.
// Expected window results go into a scoreboard queue and are popped when the DUT hands over a result.
module tb_prod_accum;

  localparam int unsigned IW = 8;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic [CW-1:0] length;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out;
  logic          overflow;

  typedef struct packed {
    logic          ovf;
    logic [AW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  prod_accum #(
    .INPUT_WIDTH(IW),
    .ACC_WIDTH  (AW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .length   (length),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int unsigned v, input logic o);
    sb.push_back(exp_t'{ovf: o, val: AW'(v)});
  endtask

  // Drive one sample; returns 1 time unit after the edge that takes it.
  task automatic send(input int unsigned v);
    in_valid = 1'b1;
    in       = IW'(v);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare on every handshake that consumes a result.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result: observed %0d expected none", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("window_sum", 32'(out), 32'(e.val));
        check("window_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    length    = 4'd4;
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out", 32'(out), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic window of 4
    length = 4'd4;
    send(1);
    send(2);
    send(3);
    push(10, 1'b0);
    send(4);
    check("basic_valid", 32'(out_valid), 1);
    check("basic_out", 32'(out), 10);
    @(posedge clock);
    #1;
    check("basic_pulse_drop", 32'(out_valid), 0);

    // Length 0 behaves as 1; back-to-back results
    length = 4'd0;
    push(7, 1'b0);
    send(7);
    check("len0_first", 32'(out), 7);
    push(9, 1'b0);
    send(9);
    check("len0_second_valid", 32'(out_valid), 1);
    check("len0_second", 32'(out), 9);
    @(posedge clock);
    #1;

    // Saturation, then sticky overflow cleared for the next window
    length = 4'd3;
    send(255);
    send(255);
    push(511, 1'b1);
    send(255);
    check("sat_out", 32'(out), 511);
    check("sat_ovf", 32'(overflow), 1);
    send(1);
    send(1);
    push(3, 1'b0);
    send(1);
    check("post_sat_ovf", 32'(overflow), 0);
    @(posedge clock);
    #1;

    // Backpressure
    length    = 4'd2;
    out_ready = 1'b0;
    send(5);
    push(11, 1'b0);
    send(6);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_out", 32'(out), 11);
      check("bp_in_ready", 32'(in_ready), 0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 1);
    send(1);
    push(2, 1'b0);
    send(1);
    check("bp_next_out", 32'(out), 2);

    // Clear mid-window drops the coincident sample
    length = 4'd4;
    send(10);
    send(20);
    clear    = 1'b1;
    in_valid = 1'b1;
    in       = 8'd30;
    #1;
    check("clr_in_ready", 32'(in_ready), 0);
    @(posedge clock);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send(1);
    send(2);
    send(3);
    push(10, 1'b0);
    send(4);
    check("clr_out", 32'(out), 10);
    @(posedge clock);
    #1;

    // Asynchronous reset mid-window
    length = 4'd4;
    send(100);
    send(100);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out", 32'(out), 0);
    check("arst_overflow", 32'(overflow), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    send(2);
    send(2);
    send(2);
    push(8, 1'b0);
    send(2);
    check("arst_next_out", 32'(out), 8);

    repeat (3) @(posedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

Windowed accumulator sitting directly downstream of the registered multiplier stage: it consumes the product stream, sums a programmable number of consecutive products, and presents each window sum on a valid/ready output. The block adds a saturation flag per result and backpressures the upstream controller via `in_ready`. The multiplier itself has no handshake, so the controller asserts `in_valid` in the cycle its registered product is meaningful.

## Interface
- `INPUT_WIDTH`, 8, width of incoming product (matches multiplier output width)
- `ACC_WIDTH`, 16, accumulator and result width; must be >= `INPUT_WIDTH`
- `COUNT_WIDTH`, 4, width of window-length field

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous abort of the partial window
- `length`  in  `COUNT_WIDTH`  samples per window; 0 is treated as 1
- `in_valid`  in  1  product sample valid
- `in_ready`  out  1  block accepts sample this cycle
- `in`  in  `INPUT_WIDTH`  product sample, unsigned
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream takes result
- `out`  out  `ACC_WIDTH`  window sum
- `overflow`  out  1  window sum saturated; qualified by `out_valid`

## Operation
- Reset values: `out_valid`=0, `out`=0, `overflow`=0, accumulator=0, sample count=0, state=IDLE. `in_ready` is combinational and reads 1 out of reset.
- Handshake: sample accepted when `in_valid && in_ready`; result consumed when `out_valid && out_ready`.
- `in_ready = !clear && (!out_valid || out_ready)`.
- States:
  - IDLE: no partial sum. An accepted sample latches `length`; 0 maps to 1.
    - Latched length 1: the result goes directly to the output register; stay IDLE.
    - Otherwise: acc=`in`, count=1, go to ACCUM.
  - ACCUM: each accepted sample adds to acc and increments count.
    - When count reaches the latched length: load the result into the output register, zero acc/count, return to IDLE.
- `length` is sampled only on the first sample of a window. Changes mid-window are ignored.
- Arithmetic:
  - `in` is zero-extended to `ACC_WIDTH + 1` for the add.
  - If the sum exceeds 2^`ACC_WIDTH`−1, acc saturates at all-ones and a window-sticky overflow bit sets.
  - The sticky bit travels to `overflow` with the result and clears at window start.
- Output register: loaded only on window completion. It holds value, `out_valid` and `overflow` stable until consumed.
  - Consume with no new load: `out_valid` drops next cycle.
  - Consume and load in the same cycle: the new result replaces the old, and `out_valid` stays 1.
- `clear`:
  - Zeroes acc, count and sticky overflow, and returns to IDLE.
  - The output register is untouched.
  - `in_ready`=0 while `clear` is high, so no sample is taken that cycle.
- `reset` asserted mid-window or while a result is pending discards everything immediately and asynchronously.

## Timing
- Latency: the result appears on `out`/`out_valid` the cycle after the last sample of the window is accepted.
- Throughput: one sample per cycle while `out_ready` is high or no result is pending. Back-to-back windows need no bubble.
- Backpressure: with a result pending and `out_ready`=0, `in_ready`=0. The upstream controller must hold the multiplier inputs or stall its pipeline.
- No combinational path from `in_valid`/`in` to any output. `in_ready` depends combinationally on `clear`, `out_ready` and registered `out_valid` only.

## Test plan
- Basic window: `length`=4; accept 1,2,3,4 on consecutive cycles with `out_ready`=1 -> `out`=10 and `overflow`=0, with `out_valid` pulsing for one cycle, one cycle after the last sample.
- Length-0 mapping and back-to-back: `length`=0; samples 7, 9 on consecutive cycles -> `out`=7 then `out`=9 on consecutive cycles, `out_valid` high for both.
- Saturation (`ACC_WIDTH`=9, `length`=3): samples 255,255,255 -> `out`=511, `overflow`=1. The next window 1,1,1 -> `out`=3, `overflow`=0.
- Backpressure: `length`=2; samples 5,6; hold `out_ready`=0 for 3 cycles -> `out`=11 stable and `in_ready`=0 throughout. Raise `out_ready` -> `in_ready` rises the same cycle, and the next window 1,1 gives `out`=2.
- Clear mid-window: `length`=4; samples 10,20, then `clear` coincident with `in_valid`, `in`=30 -> sample dropped (`in_ready`=0). Then 1,2,3,4 -> `out`=10.
- Reset mid-operation: `length`=4, samples 100,100, assert `reset` asynchronously -> `out_valid`=0, `out`=0 and `overflow`=0 immediately. After release, 2,2,2,2 -> `out`=8.
